stopwatch_ctrl: RTL

Control block for the stopwatch. Sequences the 100 Hz divider: drives its start_stop enable and consumes its divided clock as a 10 ms tick. Owns the start/stop/lap/clear state machine and the BCD mm:ss:cc time count, and presents a live or lap-frozen value to the display driver.

---
 rtl/stopwatch_pkg.sv | 31 +++
 rtl/bcd_time_counter.sv | 121 ++++++++++++
 rtl/stopwatch_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state encoding,
// BCD digit width and limits, and display word width.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;
    localparam int DISP_W  = 24;
    localparam int CS_MAX  = 99;
    localparam int SEC_MAX = 59;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    typedef logic [DIGIT_W-1:0] digit_t;

    // Tens / units digit of a small decimal constant.
    function automatic digit_t tens_of(input int v);
        return digit_t'(v / 10);
    endfunction

    function automatic digit_t units_of(input int v);
        return digit_t'(v % 10);
    endfunction

    localparam digit_t DIG_ONE = digit_t'(1);
    localparam digit_t DIG_MAX = digit_t'(9);

endpackage

// File: rtl/bcd_time_counter.sv
// Cascaded BCD mm:ss:cc counter. Increments one centisecond per inc_i,
// wraps from MAX_MIN:59:99 to 00:00:00 and latches a sticky overflow flag.
// clr_i zeroes the count and the overflow flag.
module bcd_time_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic [DISP_W-1:0] count_o,
    output logic              ovf_o
);

    localparam digit_t CS_T_LIM  = tens_of(CS_MAX);
    localparam digit_t CS_U_LIM  = units_of(CS_MAX);
    localparam digit_t SEC_T_LIM = tens_of(SEC_MAX);
    localparam digit_t SEC_U_LIM = units_of(SEC_MAX);
    localparam digit_t MIN_T_LIM = tens_of(MAX_MIN);
    localparam digit_t MIN_U_LIM = units_of(MAX_MIN);

    digit_t cs_u_q, cs_t_q, sec_u_q, sec_t_q, min_u_q, min_t_q;
    digit_t cs_u_d, cs_t_d, sec_u_d, sec_t_d, min_u_d, min_t_d;
    logic   ovf_q;
    logic   at_max;
    logic   wrap;

    assign at_max = (cs_u_q  == CS_U_LIM)  && (cs_t_q  == CS_T_LIM)  &&
                    (sec_u_q == SEC_U_LIM) && (sec_t_q == SEC_T_LIM) &&
                    (min_u_q == MIN_U_LIM) && (min_t_q == MIN_T_LIM);

    // Next count: ripple the carry digit by digit, full wrap at the top value.
    always_comb begin
        cs_u_d  = cs_u_q;
        cs_t_d  = cs_t_q;
        sec_u_d = sec_u_q;
        sec_t_d = sec_t_q;
        min_u_d = min_u_q;
        min_t_d = min_t_q;
        wrap    = 1'b0;
        if (clr_i) begin
            cs_u_d  = '0;
            cs_t_d  = '0;
            sec_u_d = '0;
            sec_t_d = '0;
            min_u_d = '0;
            min_t_d = '0;
        end else if (inc_i) begin
            if (at_max) begin
                cs_u_d  = '0;
                cs_t_d  = '0;
                sec_u_d = '0;
                sec_t_d = '0;
                min_u_d = '0;
                min_t_d = '0;
                wrap    = 1'b1;
            end else if (cs_u_q != DIG_MAX) begin
                cs_u_d = cs_u_q + DIG_ONE;
            end else begin
                cs_u_d = '0;
                if (cs_t_q != CS_T_LIM) begin
                    cs_t_d = cs_t_q + DIG_ONE;
                end else begin
                    cs_t_d = '0;
                    if (sec_u_q != DIG_MAX) begin
                        sec_u_d = sec_u_q + DIG_ONE;
                    end else begin
                        sec_u_d = '0;
                        if (sec_t_q != SEC_T_LIM) begin
                            sec_t_d = sec_t_q + DIG_ONE;
                        end else begin
                            sec_t_d = '0;
                            if (min_u_q != DIG_MAX) begin
                                min_u_d = min_u_q + DIG_ONE;
                            end else begin
                                min_u_d = '0;
                                min_t_d = min_t_q + DIG_ONE;
                            end
                        end
                    end
                end
            end
        end
    end

    // Count digit registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_u_q  <= '0;
            cs_t_q  <= '0;
            sec_u_q <= '0;
            sec_t_q <= '0;
            min_u_q <= '0;
            min_t_q <= '0;
        end else begin
            cs_u_q  <= cs_u_d;
            cs_t_q  <= cs_t_d;
            sec_u_q <= sec_u_d;
            sec_t_q <= sec_t_d;
            min_u_q <= min_u_d;
            min_t_q <= min_t_d;
        end
    end

    // Sticky overflow: set on wrap, cleared only together with the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            ovf_q <= 1'b0;
        end else if (wrap) begin
            ovf_q <= 1'b1;
        end
    end

    assign count_o = {min_t_q, min_u_q, sec_t_q, sec_u_q, cs_t_q, cs_u_q};
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronises buttons and the 100 Hz divider output,
// runs the start/stop/lap/clear FSM, enables the divider, keeps the BCD
// time count and drives a registered live-or-lap display word.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MIN     = 59
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_ss,
    input  logic              btn_lap,
    input  logic              btn_clr,
    input  logic              tick_in,
    output logic              run_en,
    output logic [DISP_W-1:0] disp_bcd,
    output logic              lap_active,
    output logic              ovf,
    output logic [1:0]        state
);

    localparam int N_IN    = 4;
    localparam int IDX_SS  = 0;
    localparam int IDX_LAP = 1;
    localparam int IDX_CLR = 2;
    localparam int IDX_TCK = 3;

    logic [N_IN-1:0]   raw;
    logic [N_IN-1:0]   sync_q [SYNC_STAGES];
    logic [N_IN-1:0]   prev_q;
    logic [N_IN-1:0]   pulse;
    logic              ss_p, lap_p, clr_p, tick_p;

    state_t            state_q, state_d;
    logic              run_en_q;
    logic [DISP_W-1:0] lap_q;
    logic [DISP_W-1:0] disp_q;
    logic [DISP_W-1:0] count;
    logic              cnt_ovf;
    logic              cnt_inc, cnt_clr, lap_load;

    assign raw = {tick_in, btn_clr, btn_lap, btn_ss};

    // Synchronizer chains plus one-behind copy for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign ss_p   = pulse[IDX_SS];
    assign lap_p  = pulse[IDX_LAP];
    assign clr_p  = pulse[IDX_CLR];
    assign tick_p = pulse[IDX_TCK];

    // FSM state register; run_en is decoded from the next state so it
    // switches on the same edge as the state itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            run_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_en_q <= (state_d == RUN) || (state_d == LAP);
        end
    end

    // Next-state logic: ss beats lap in RUN/LAP, clr beats ss in PAUSE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (ss_p) state_d = RUN;
            RUN: begin
                if (ss_p)       state_d = PAUSE;
                else if (lap_p) state_d = LAP;
            end
            LAP: begin
                if (ss_p)       state_d = PAUSE;
                else if (lap_p) state_d = RUN;
            end
            PAUSE: begin
                if (clr_p)     state_d = IDLE;
                else if (ss_p) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / strobe decode from the current state; ticks outside
    // RUN/LAP are simply dropped.
    always_comb begin
        lap_active = (state_q == LAP);
        cnt_inc    = tick_p && ((state_q == RUN) || (state_q == LAP));
        cnt_clr    = clr_p && (state_q == PAUSE);
        lap_load   = lap_p && !ss_p && (state_q == RUN);
    end

    bcd_time_counter #(
        .MAX_MIN (MAX_MIN)
    ) u_count (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (cnt_inc),
        .clr_i   (cnt_clr),
        .count_o (count),
        .ovf_o   (cnt_ovf)
    );

    // Lap register: snapshot of the count on entry to LAP, zeroed on clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_q <= '0;
        end else if (cnt_clr) begin
            lap_q <= '0;
        end else if (lap_load) begin
            lap_q <= count;
        end
    end

    // Registered display: frozen lap value while in LAP, live count otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_q <= '0;
        end else begin
            disp_q <= (state_q == LAP) ? lap_q : count;
        end
    end

    assign run_en   = run_en_q;
    assign disp_bcd = disp_q;
    assign ovf      = cnt_ovf;
    assign state    = state_q;

endmodule
